// File: rtl/ashi_reg_bank_pkg.sv
// Shared register map, response codes and FSM state types for the ASHI register bank.
package ashi_reg_bank_pkg;
  localparam logic [31:0] IDX_ID       = 32'd0;
  localparam logic [31:0] IDX_SCRATCH  = 32'd1;
  localparam logic [31:0] IDX_IRQ_STAT = 32'd2;
  localparam logic [31:0] IDX_IRQ_EN   = 32'd3;
  localparam logic [31:0] IDX_CTL0     = 32'd4;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_BUSY} w_state_t;
  typedef enum logic {R_IDLE, R_BUSY} r_state_t;
endpackage

// File: rtl/ashi_reg_bank_if.sv
// ASHI strobe/index/data bundle between the AXI4-Lite slave adapter (master) and a register handler (slave).
interface ashi_reg_bank_if;
  import ashi_reg_bank_pkg::*;

  logic [31:0] ASHI_WINDX;
  logic [31:0] ASHI_WDATA;
  logic        ASHI_WRITE;
  logic        ASHI_WIDLE;
  resp_t       ASHI_WRESP;
  logic [31:0] ASHI_RINDX;
  logic        ASHI_READ;
  logic        ASHI_RIDLE;
  logic [31:0] ASHI_RDATA;
  resp_t       ASHI_RRESP;

  modport master (
    output ASHI_WINDX, ASHI_WDATA, ASHI_WRITE, ASHI_RINDX, ASHI_READ,
    input  ASHI_WIDLE, ASHI_WRESP, ASHI_RIDLE, ASHI_RDATA, ASHI_RRESP
  );

  modport slave (
    input  ASHI_WINDX, ASHI_WDATA, ASHI_WRITE, ASHI_RINDX, ASHI_READ,
    output ASHI_WIDLE, ASHI_WRESP, ASHI_RIDLE, ASHI_RDATA, ASHI_RRESP
  );
endinterface

// File: rtl/ashi_reg_bank_irq_edge_latch.sv
// Per-bit rising-edge detector feeding a W1C sticky status register; status visible 1 cycle after the edge.
// No backpressure; a set and a clear on the same bit in one cycle leave the bit set.
module irq_edge_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] src,
  input  logic [W-1:0] clr_mask,
  input  logic         clr_stb,
  output logic [W-1:0] status
);
  logic [W-1:0] r_prev;
  logic [W-1:0] r_status;
  logic [W-1:0] w_rise;
  logic [W-1:0] w_clr;

  assign w_rise = src & ~r_prev;
  assign w_clr  = clr_stb ? clr_mask : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev   <= '0;
      r_status <= '0;
    end else begin
      r_prev   <= src;
      r_status <= (r_status & ~w_clr) | w_rise;
    end
  end

  assign status = r_status;
endmodule

// File: rtl/ashi_reg_bank.sv
// ASHI register bank: ID, scratch, W1C IRQ status/enable, RW control and RO status registers.
// Writes and reads each take 2 cycles (WIDLE/RIDLE low for one); strobes arriving while busy are ignored.
module ashi_reg_bank
  import ashi_reg_bank_pkg::*;
#(
  parameter logic [31:0] BLOCK_ID  = 32'h0000_0000,
  parameter int          NUM_CTL   = 4,
  parameter int          NUM_STAT  = 4,
  parameter int          IRQ_W     = 8,
  parameter logic [31:0] CTL_RESET = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  ashi_reg_bank_if.slave           ashi,
  output logic [NUM_CTL*32-1:0]    ctl_out,
  output logic [NUM_CTL-1:0]       ctl_wstb,
  input  logic [NUM_STAT*32-1:0]   stat_in,
  input  logic [IRQ_W-1:0]         irq_src,
  output logic                     irq_out
);
  localparam logic [31:0] IDX_STAT0 = IDX_CTL0 + 32'(NUM_CTL);

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;
  logic w_wlatch, w_commit, w_rlatch, w_rcapture;

  logic [31:0]            r_windx, r_wdata, r_rindx, r_rdata, r_scratch;
  resp_t                  r_wresp, r_rresp;
  logic [IRQ_W-1:0]       r_irq_en;
  logic [NUM_CTL*32-1:0]  r_ctl;
  logic [NUM_CTL-1:0]     r_ctl_wstb;
  logic                   r_irq_out;

  logic [IRQ_W-1:0]   w_irq_status;
  logic [31:0]        w_irq_stat32, w_irq_en32, w_rdata;
  resp_t              w_rresp;
  logic               w_wr_ok, w_irq_clr_stb;
  logic [NUM_CTL-1:0] w_ctl_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_rstate_nxt = r_rstate;
    w_wlatch     = 1'b0;
    w_commit     = 1'b0;
    w_rlatch     = 1'b0;
    w_rcapture   = 1'b0;
    case (r_wstate)
      W_IDLE: if (ashi.ASHI_WRITE) begin w_wlatch = 1'b1; w_wstate_nxt = W_BUSY; end
      W_BUSY: begin w_commit = 1'b1; w_wstate_nxt = W_IDLE; end
      default: w_wstate_nxt = W_IDLE;
    endcase
    case (r_rstate)
      R_IDLE: if (ashi.ASHI_READ) begin w_rlatch = 1'b1; w_rstate_nxt = R_BUSY; end
      R_BUSY: begin w_rcapture = 1'b1; w_rstate_nxt = R_IDLE; end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Writable targets only; ID and STAT fall through as SLVERR.
  always_comb begin
    w_wr_ok   = 1'b0;
    w_ctl_sel = '0;
    if (r_windx == IDX_SCRATCH || r_windx == IDX_IRQ_STAT || r_windx == IDX_IRQ_EN) w_wr_ok = 1'b1;
    for (int k = 0; k < NUM_CTL; k++) begin
      if (r_windx == IDX_CTL0 + 32'(k)) begin
        w_ctl_sel[k] = 1'b1;
        w_wr_ok      = 1'b1;
      end
    end
  end

  assign w_irq_clr_stb = w_commit && (r_windx == IDX_IRQ_STAT);

  irq_edge_latch #(.W(IRQ_W)) u_irq (
    .clk      (clk),
    .reset    (reset),
    .src      (irq_src),
    .clr_mask (r_wdata[IRQ_W-1:0]),
    .clr_stb  (w_irq_clr_stb),
    .status   (w_irq_status)
  );

  always_comb begin
    w_irq_stat32              = '0;
    w_irq_stat32[IRQ_W-1:0]   = w_irq_status;
    w_irq_en32                = '0;
    w_irq_en32[IRQ_W-1:0]     = r_irq_en;
    w_rdata                   = '0;
    w_rresp                   = RESP_SLVERR;
    if (r_rindx == IDX_ID)       begin w_rdata = BLOCK_ID;     w_rresp = RESP_OKAY; end
    if (r_rindx == IDX_SCRATCH)  begin w_rdata = r_scratch;    w_rresp = RESP_OKAY; end
    if (r_rindx == IDX_IRQ_STAT) begin w_rdata = w_irq_stat32; w_rresp = RESP_OKAY; end
    if (r_rindx == IDX_IRQ_EN)   begin w_rdata = w_irq_en32;   w_rresp = RESP_OKAY; end
    for (int k = 0; k < NUM_CTL; k++) begin
      if (r_rindx == IDX_CTL0 + 32'(k)) begin w_rdata = r_ctl[k*32 +: 32]; w_rresp = RESP_OKAY; end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (r_rindx == IDX_STAT0 + 32'(k)) begin w_rdata = stat_in[k*32 +: 32]; w_rresp = RESP_OKAY; end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_windx    <= '0;
      r_wdata    <= '0;
      r_rindx    <= '0;
      r_rdata    <= '0;
      r_wresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
      r_scratch  <= '0;
      r_irq_en   <= '0;
      r_ctl      <= {NUM_CTL{CTL_RESET}};
      r_ctl_wstb <= '0;
      r_irq_out  <= 1'b0;
    end else begin
      r_ctl_wstb <= '0;
      r_irq_out  <= |(w_irq_status & r_irq_en);
      if (w_wlatch) begin
        r_windx <= ashi.ASHI_WINDX;
        r_wdata <= ashi.ASHI_WDATA;
      end
      if (w_commit) begin
        r_wresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (r_windx == IDX_SCRATCH) r_scratch <= r_wdata;
        if (r_windx == IDX_IRQ_EN)  r_irq_en  <= r_wdata[IRQ_W-1:0];
        for (int k = 0; k < NUM_CTL; k++) begin
          if (w_ctl_sel[k]) begin
            r_ctl[k*32 +: 32] <= r_wdata;
            r_ctl_wstb[k]     <= 1'b1;
          end
        end
      end
      if (w_rlatch) r_rindx <= ashi.ASHI_RINDX;
      if (w_rcapture) begin
        r_rdata <= w_rdata;
        r_rresp <= w_rresp;
      end
    end
  end

  assign ashi.ASHI_WIDLE = (r_wstate == W_IDLE);
  assign ashi.ASHI_RIDLE = (r_rstate == R_IDLE);
  assign ashi.ASHI_WRESP = r_wresp;
  assign ashi.ASHI_RRESP = r_rresp;
  assign ashi.ASHI_RDATA = r_rdata;
  assign ctl_out         = r_ctl;
  assign ctl_wstb        = r_ctl_wstb;
  assign irq_out         = r_irq_out;
endmodule

// File: tb/tb_ashi_reg_bank.sv
// Self-checking bench for ashi_reg_bank: directed scenarios plus randomized traffic against a register-map model.
module tb_ashi_reg_bank;
  import ashi_reg_bank_pkg::*;

  localparam logic [31:0] BID  = 32'hC0DE_0001;
  localparam int          NC   = 4;
  localparam int          NS   = 4;
  localparam int          IW   = 8;
  localparam logic [31:0] CRST = 32'h1111_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ashi_reg_bank_if bus();
  logic [NC*32-1:0] ctl_out;
  logic [NC-1:0]    ctl_wstb;
  logic [NS*32-1:0] stat_in;
  logic [IW-1:0]    irq_src;
  logic             irq_out;

  ashi_reg_bank #(
    .BLOCK_ID(BID), .NUM_CTL(NC), .NUM_STAT(NS), .IRQ_W(IW), .CTL_RESET(CRST)
  ) dut (
    .clk(clk), .reset(reset), .ashi(bus.slave),
    .ctl_out(ctl_out), .ctl_wstb(ctl_wstb), .stat_in(stat_in),
    .irq_src(irq_src), .irq_out(irq_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the register map.
  logic [31:0] m_scratch, m_en;
  logic [IW-1:0] m_irq;
  logic [31:0] m_ctl [NC];
  logic [31:0] m_stat [NS];

  task automatic model_reset();
    m_scratch = '0; m_en = '0; m_irq = '0;
    for (int k = 0; k < NC; k++) m_ctl[k] = CRST;
  endtask

  function automatic logic [NC*32-1:0] exp_ctl();
    logic [NC*32-1:0] v;
    for (int k = 0; k < NC; k++) v[k*32 +: 32] = m_ctl[k];
    return v;
  endfunction

  task automatic drive_stat();
    for (int k = 0; k < NS; k++) stat_in[k*32 +: 32] = m_stat[k];
  endtask

  task automatic model_read(input logic [31:0] idx, output logic [31:0] d, output logic [1:0] r);
    d = '0; r = 2'b10;
    if (idx == 32'd0) begin d = BID; r = 2'b00; end
    if (idx == 32'd1) begin d = m_scratch; r = 2'b00; end
    if (idx == 32'd2) begin d = {24'h0, m_irq}; r = 2'b00; end
    if (idx == 32'd3) begin d = m_en; r = 2'b00; end
    for (int k = 0; k < NC; k++) if (idx == 32'(4 + k)) begin d = m_ctl[k]; r = 2'b00; end
    for (int k = 0; k < NS; k++) if (idx == 32'(4 + NC + k)) begin d = m_stat[k]; r = 2'b00; end
  endtask

  task automatic model_write(input logic [31:0] idx, input logic [31:0] data,
                             output logic [1:0] r, output logic [NC-1:0] stb);
    r = 2'b10; stb = '0;
    if (idx == 32'd1) begin m_scratch = data; r = 2'b00; end
    if (idx == 32'd2) begin m_irq = m_irq & ~data[IW-1:0]; r = 2'b00; end
    if (idx == 32'd3) begin m_en = {24'h0, data[IW-1:0]}; r = 2'b00; end
    for (int k = 0; k < NC; k++) if (idx == 32'(4 + k)) begin m_ctl[k] = data; stb[k] = 1'b1; r = 2'b00; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Write transaction; busy_src is driven on irq_src during the commit cycle.
  task automatic do_write(input logic [31:0] idx, input logic [31:0] data, input logic [IW-1:0] busy_src);
    bus.ASHI_WINDX = idx; bus.ASHI_WDATA = data; bus.ASHI_WRITE = 1'b1;
    tick();
    bus.ASHI_WRITE = 1'b0;
    if (busy_src != '0) irq_src = busy_src;
    n_checks++;
    if (bus.ASHI_WIDLE !== 1'b0) begin n_errors++; $display("FAIL widle_busy: got %b want 0", bus.ASHI_WIDLE); end
    tick();
    if (busy_src != '0) irq_src = '0;
    n_checks++;
    if (bus.ASHI_WIDLE !== 1'b1) begin n_errors++; $display("FAIL widle_done: got %b want 1", bus.ASHI_WIDLE); end
  endtask

  task automatic do_read(input logic [31:0] idx, output logic [31:0] d, output logic [1:0] r);
    bus.ASHI_RINDX = idx; bus.ASHI_READ = 1'b1;
    tick();
    bus.ASHI_READ = 1'b0;
    n_checks++;
    if (bus.ASHI_RIDLE !== 1'b0) begin n_errors++; $display("FAIL ridle_busy: got %b want 0", bus.ASHI_RIDLE); end
    tick();
    n_checks++;
    if (bus.ASHI_RIDLE !== 1'b1) begin n_errors++; $display("FAIL ridle_done: got %b want 1", bus.ASHI_RIDLE); end
    d = bus.ASHI_RDATA; r = bus.ASHI_RRESP;
  endtask

  task automatic test_reset();
    bus.ASHI_WINDX = '0; bus.ASHI_WDATA = '0; bus.ASHI_WRITE = 1'b0;
    bus.ASHI_RINDX = '0; bus.ASHI_READ = 1'b0;
    irq_src = '0;
    for (int k = 0; k < NS; k++) m_stat[k] = $urandom;
    drive_stat();
    model_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus.ASHI_WIDLE !== 1'b1) begin n_errors++; $display("FAIL rst_widle: got %b want 1", bus.ASHI_WIDLE); end
    n_checks++; if (bus.ASHI_RIDLE !== 1'b1) begin n_errors++; $display("FAIL rst_ridle: got %b want 1", bus.ASHI_RIDLE); end
    n_checks++; if (bus.ASHI_RDATA !== 32'h0) begin n_errors++; $display("FAIL rst_rdata: got %h want 0", bus.ASHI_RDATA); end
    n_checks++; if (bus.ASHI_RRESP !== 2'b00) begin n_errors++; $display("FAIL rst_rresp: got %b want 00", bus.ASHI_RRESP); end
    n_checks++; if (bus.ASHI_WRESP !== 2'b00) begin n_errors++; $display("FAIL rst_wresp: got %b want 00", bus.ASHI_WRESP); end
    n_checks++; if (ctl_out !== exp_ctl()) begin n_errors++; $display("FAIL rst_ctl: got %h want %h", ctl_out, exp_ctl()); end
    n_checks++; if (ctl_wstb !== '0) begin n_errors++; $display("FAIL rst_wstb: got %b want 0", ctl_wstb); end
    n_checks++; if (irq_out !== 1'b0) begin n_errors++; $display("FAIL rst_irq: got %b want 0", irq_out); end
  endtask

  task automatic test_id_read();
    logic [31:0] d; logic [1:0] r;
    do_read(32'd0, d, r);
    n_checks++; if (d !== 32'hC0DE_0001) begin n_errors++; $display("FAIL id_data: got %h want c0de0001", d); end
    n_checks++; if (r !== 2'b00) begin n_errors++; $display("FAIL id_resp: got %b want 00", r); end
  endtask

  task automatic test_ctl_write();
    logic [31:0] d; logic [1:0] r, er; logic [NC-1:0] es;
    model_write(32'd4, 32'hA5A5_1234, er, es);
    do_write(32'd4, 32'hA5A5_1234, '0);
    n_checks++; if (bus.ASHI_WRESP !== er) begin n_errors++; $display("FAIL ctl_wresp: got %b want %b", bus.ASHI_WRESP, er); end
    n_checks++; if (ctl_wstb !== es) begin n_errors++; $display("FAIL ctl_wstb: got %b want %b", ctl_wstb, es); end
    n_checks++; if (ctl_out[31:0] !== 32'hA5A5_1234) begin n_errors++; $display("FAIL ctl0_val: got %h want a5a51234", ctl_out[31:0]); end
    n_checks++; if (ctl_out !== exp_ctl()) begin n_errors++; $display("FAIL ctl_all: got %h want %h", ctl_out, exp_ctl()); end
    tick();
    n_checks++; if (ctl_wstb !== '0) begin n_errors++; $display("FAIL ctl_wstb_pulse: got %b want 0", ctl_wstb); end
    do_read(32'd4, d, r);
    n_checks++; if (d !== 32'hA5A5_1234 || r !== 2'b00) begin n_errors++; $display("FAIL ctl_readback: got %h/%b want a5a51234/00", d, r); end
  endtask

  task automatic test_bad_index();
    logic [31:0] bad_w [5];
    logic [31:0] bad_r [4];
    logic [31:0] d; logic [1:0] r;
    bad_w = '{32'd0, 32'd12, 32'd9, 32'h8000_0004, 32'hFFFF_FFFF};
    bad_r = '{32'd100, 32'd12, 32'h0000_0104, 32'h8000_0001};
    for (int i = 0; i < 5; i++) begin
      do_write(bad_w[i], $urandom, '0);
      n_checks++; if (bus.ASHI_WRESP !== 2'b10) begin n_errors++; $display("FAIL badw_resp[%0d]: got %b want 10", i, bus.ASHI_WRESP); end
      n_checks++; if (ctl_wstb !== '0 || ctl_out !== exp_ctl()) begin n_errors++; $display("FAIL badw_side[%0d]: wstb %b ctl %h want 0 %h", i, ctl_wstb, ctl_out, exp_ctl()); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(bad_r[i], d, r);
      n_checks++; if (d !== 32'h0 || r !== 2'b10) begin n_errors++; $display("FAIL badr[%0d]: got %h/%b want 0/10", i, d, r); end
    end
    do_read(32'd11, d, r);
    n_checks++; if (d !== m_stat[3] || r !== 2'b00) begin n_errors++; $display("FAIL last_stat: got %h/%b want %h/00", d, r, m_stat[3]); end
  endtask

  task automatic test_irq();
    logic [31:0] d, ed; logic [1:0] r, er; logic [NC-1:0] es;
    irq_src = 8'h08; tick(); irq_src = '0;
    m_irq = m_irq | 8'h08;
    model_write(32'd3, 32'd8, er, es);
    do_write(32'd3, 32'd8, '0);
    n_checks++; if (irq_out !== 1'b0) begin n_errors++; $display("FAIL irq_lat0: got %b want 0", irq_out); end
    tick();
    n_checks++; if (irq_out !== 1'b1) begin n_errors++; $display("FAIL irq_assert: got %b want 1", irq_out); end
    do_read(32'd2, d, r);
    n_checks++; if (d !== 32'd8 || r !== 2'b00) begin n_errors++; $display("FAIL irq_stat: got %h/%b want 8/00", d, r); end
    // Clear and fresh edge on the same cycle: set wins.
    model_write(32'd2, 32'd8, er, es);
    m_irq = m_irq | 8'h08;
    do_write(32'd2, 32'd8, 8'h08);
    do_read(32'd2, d, r);
    model_read(32'd2, ed, er);
    n_checks++; if (d !== ed || d !== 32'd8) begin n_errors++; $display("FAIL irq_setwins: got %h want %h", d, ed); end
    model_write(32'd2, 32'd8, er, es);
    do_write(32'd2, 32'd8, '0);
    n_checks++; if (irq_out !== 1'b1) begin n_errors++; $display("FAIL irq_hold: got %b want 1", irq_out); end
    tick();
    n_checks++; if (irq_out !== 1'b0) begin n_errors++; $display("FAIL irq_deassert: got %b want 0", irq_out); end
    do_read(32'd2, d, r);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL irq_cleared: got %h want 0", d); end
    for (int i = 0; i < 6; i++) begin
      logic [IW-1:0] mask, clr;
      mask = IW'($urandom); clr = IW'($urandom);
      irq_src = mask; tick(); irq_src = '0; tick();
      m_irq = m_irq | mask;
      do_read(32'd2, d, r); model_read(32'd2, ed, er);
      n_checks++; if (d !== ed) begin n_errors++; $display("FAIL irq_rand_set[%0d]: got %h want %h", i, d, ed); end
      model_write(32'd2, {24'h0, clr}, er, es);
      do_write(32'd2, {24'h0, clr}, '0);
      do_read(32'd2, d, r); model_read(32'd2, ed, er);
      n_checks++; if (d !== ed) begin n_errors++; $display("FAIL irq_rand_clr[%0d]: got %h want %h", i, d, ed); end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d, old; logic [1:0] r, er; logic [NC-1:0] es;
    m_stat[1] = 32'h1234_5678; drive_stat();
    bus.ASHI_RINDX = 32'(4 + NC + 1); bus.ASHI_READ = 1'b1;
    bus.ASHI_WINDX = 32'd1; bus.ASHI_WDATA = 32'd7; bus.ASHI_WRITE = 1'b1;
    tick();
    bus.ASHI_READ = 1'b0; bus.ASHI_WRITE = 1'b0;
    n_checks++; if (bus.ASHI_WIDLE !== 1'b0 || bus.ASHI_RIDLE !== 1'b0) begin n_errors++; $display("FAIL sim_busy: widle %b ridle %b want 0 0", bus.ASHI_WIDLE, bus.ASHI_RIDLE); end
    tick();
    model_write(32'd1, 32'd7, er, es);
    n_checks++; if (bus.ASHI_RDATA !== 32'h1234_5678 || bus.ASHI_RRESP !== 2'b00) begin n_errors++; $display("FAIL sim_stat: got %h/%b want 12345678/00", bus.ASHI_RDATA, bus.ASHI_RRESP); end
    n_checks++; if (bus.ASHI_WRESP !== er || bus.ASHI_WIDLE !== 1'b1) begin n_errors++; $display("FAIL sim_wr: resp %b idle %b want %b 1", bus.ASHI_WRESP, bus.ASHI_WIDLE, er); end
    do_read(32'd1, d, r);
    n_checks++; if (d !== 32'd7) begin n_errors++; $display("FAIL sim_scratch: got %h want 7", d); end
    old = m_scratch;
    bus.ASHI_RINDX = 32'd1; bus.ASHI_READ = 1'b1;
    bus.ASHI_WINDX = 32'd1; bus.ASHI_WDATA = $urandom; bus.ASHI_WRITE = 1'b1;
    model_write(32'd1, bus.ASHI_WDATA, er, es);
    tick(); bus.ASHI_READ = 1'b0; bus.ASHI_WRITE = 1'b0; tick();
    n_checks++; if (bus.ASHI_RDATA !== old) begin n_errors++; $display("FAIL sim_prewrite: got %h want %h", bus.ASHI_RDATA, old); end
  endtask

  task automatic test_random();
    logic [31:0] idx, data, d, ed; logic [1:0] r, er; logic [NC-1:0] es;
    for (int i = 0; i < 60; i++) begin
      idx  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 13));
      data = $urandom;
      if ($urandom_range(0, 3) == 0) begin m_stat[$urandom_range(0, NS-1)] = $urandom; drive_stat(); end
      if ($urandom_range(0, 2) == 0) begin
        model_read(idx, ed, er);
        do_read(idx, d, r);
        n_checks++; if (d !== ed || r !== er) begin n_errors++; $display("FAIL rnd_read[%0d] idx %h: got %h/%b want %h/%b", i, idx, d, r, ed, er); end
      end else begin
        model_write(idx, data, er, es);
        do_write(idx, data, '0);
        n_checks++; if (bus.ASHI_WRESP !== er || ctl_wstb !== es) begin n_errors++; $display("FAIL rnd_write[%0d] idx %h: resp %b wstb %b want %b %b", i, idx, bus.ASHI_WRESP, ctl_wstb, er, es); end
        n_checks++; if (ctl_out !== exp_ctl()) begin n_errors++; $display("FAIL rnd_ctl[%0d]: got %h want %h", i, ctl_out, exp_ctl()); end
      end
      tick();
      n_checks++; if (irq_out !== |(m_irq & m_en[IW-1:0])) begin n_errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq_out, |(m_irq & m_en[IW-1:0])); end
    end
  endtask

  task automatic test_reset_mid();
    bus.ASHI_WINDX = 32'd5; bus.ASHI_WDATA = $urandom; bus.ASHI_WRITE = 1'b1;
    bus.ASHI_RINDX = 32'd1; bus.ASHI_READ = 1'b1;
    tick();
    bus.ASHI_WRITE = 1'b0; bus.ASHI_READ = 1'b0;
    n_checks++; if (bus.ASHI_WIDLE !== 1'b0) begin n_errors++; $display("FAIL mid_busy: got %b want 0", bus.ASHI_WIDLE); end
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (bus.ASHI_WIDLE !== 1'b1 || bus.ASHI_RIDLE !== 1'b1) begin n_errors++; $display("FAIL mid_idle: widle %b ridle %b want 1 1", bus.ASHI_WIDLE, bus.ASHI_RIDLE); end
    n_checks++; if (ctl_out !== exp_ctl()) begin n_errors++; $display("FAIL mid_ctl: got %h want %h", ctl_out, exp_ctl()); end
    n_checks++; if (bus.ASHI_RDATA !== 32'h0 || bus.ASHI_WRESP !== 2'b00) begin n_errors++; $display("FAIL mid_outs: rdata %h wresp %b want 0 00", bus.ASHI_RDATA, bus.ASHI_WRESP); end
    tick();
    n_checks++; if (ctl_wstb !== '0) begin n_errors++; $display("FAIL mid_wstb_rst: got %b want 0", ctl_wstb); end
    reset = 1'b0;
    tick();
    n_checks++; if (ctl_wstb !== '0 || ctl_out !== exp_ctl()) begin n_errors++; $display("FAIL mid_after: wstb %b ctl %h want 0 %h", ctl_wstb, ctl_out, exp_ctl()); end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_ctl_write();
    test_bad_index();
    test_irq();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
